// File: rtl/async_handshake_source_if.sv
// Handshake bundle for async_handshake_source.
// The master modport is the source block itself. The slave modport is the
// producer/sink environment around it.
interface async_handshake_source_if #(
    parameter int WIDTH = 2
);
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_req;
    logic [WIDTH-1:0] io_data;
    logic             io_ack;
    logic             io_proto_err;
    logic             io_timeout;

    modport master (
        input  io_enq_valid,
        input  io_enq_bits,
        input  io_ack,
        output io_enq_ready,
        output io_req,
        output io_data,
        output io_proto_err,
        output io_timeout
    );

    modport slave (
        output io_enq_valid,
        output io_enq_bits,
        output io_ack,
        input  io_enq_ready,
        input  io_req,
        input  io_data,
        input  io_proto_err,
        input  io_timeout
    );
endinterface

// File: rtl/async_handshake_source.sv
// Source side of a two-phase (toggle) handshake clock-domain crossing.
// A word accepted over ready/valid is held on io_data and io_req toggles.
// The block then waits until the sink's io_ack toggle has passed through a
// SYNC_DEPTH-flop synchronizer and matches io_req again.
// Optional feature: define ASYNC_SOURCE_TIMEOUT_EN to add a saturating busy
// counter that drives io_timeout. Without it, io_timeout is tied to 0.
module async_handshake_source #(
    parameter int WIDTH          = 2,
    parameter int SYNC_DEPTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    async_handshake_source_if.master      bus
);

    if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
        $error("async_handshake_source: SYNC_DEPTH must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("async_handshake_source: TIMEOUT_CYCLES must be at least 1");
    end

    logic                  req_q;
    logic [WIDTH-1:0]      data_q;
    logic [SYNC_DEPTH-1:0] ack_sync;
    logic                  ack_s;
    logic                  ack_s_d;
    logic                  err_q;
    logic                  busy;
    logic                  accept;

    // IDLE/BUSY comes from the toggle parity alone. There is no separate state flop.
    assign ack_s  = ack_sync[SYNC_DEPTH-1];
    assign busy   = (req_q != ack_s);
    assign accept = !busy && bus.io_enq_valid;

    // Synchronize the asynchronous ack toggle. Only stage 0 sees io_ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_DEPTH-2:0], bus.io_ack};
        end
    end

    // Capture the payload and toggle the request on accept. Hold both while busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            req_q  <= ~req_q;
            data_q <= bus.io_enq_bits;
        end
    end

    // Flag an ack edge that arrives while no request is outstanding. The flag is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_s_d <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_s_d <= ack_s;
            if ((ack_s != ack_s_d) && (req_q == ack_s_d)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.io_req       = req_q;
    assign bus.io_data      = data_q;
    assign bus.io_enq_ready = !busy;
    assign bus.io_proto_err = err_q;

`ifdef ASYNC_SOURCE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    // Next busy count: clear on accept, count busy cycles, and saturate at the limit.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (accept) begin
            busy_cnt_d = '0;
        end else if (busy && (busy_cnt_q != CNT_MAX)) begin
            busy_cnt_d = busy_cnt_q + 1'b1;
        end
    end

    // Busy counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Qualify with busy so the flag drops in the same cycle the block returns to idle.
    assign bus.io_timeout = busy && (busy_cnt_q == CNT_MAX);
`else
    assign bus.io_timeout = 1'b0;
`endif

endmodule
